// File: rtl/systolic_data_buffer.sv
// Systolic-array input feeder: captures an ifmap, unrolls it into MUL rows or CONV
// im2col vectors, and emits them diagonally skewed across the output lanes.
module systolic_data_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned HEIGHT     = 8,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HEIGHT_W   = $clog2(HEIGHT)
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 layer_info_valid,
    input  logic [HEIGHT_W:0]                    ifmap_height_i,
    input  logic [HEIGHT_W:0]                    ifmap_width_i,
    input  logic [HEIGHT_W:0]                    weight_height_i,
    input  logic                                 op_i,
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]   ifmap_i,
    input  logic                                 send_sd_en,
    output logic                                 sd_ov,
    output logic [WIDTH*DATA_WIDTH-1:0]          sd_od
);

    localparam int unsigned DIM_W = HEIGHT_W + 1;
    localparam int unsigned CNT_W = $clog2(HEIGHT*HEIGHT*WIDTH + WIDTH + 1) + 1;
    localparam int unsigned IDX_W = $clog2(HEIGHT*WIDTH*DATA_WIDTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                           r_state;
    logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] r_ifmap;
    logic                             r_op;
    logic [DIM_W-1:0]                 r_k, r_p, r_l;
    logic [DIM_W-1:0]                 r_row, r_kr, r_col;
    logic [CNT_W-1:0]                 r_n, r_n_max, r_t, r_t_last;
    logic [DATA_WIDTH-1:0]            r_dly [WIDTH][WIDTH];

    logic                             w_legal, w_start, w_finish, w_gen;
    logic [DIM_W-1:0]                 w_o_in, w_p_in, w_l_in;
    logic [CNT_W-1:0]                 w_n_in, w_t_last_in;
    logic [DIM_W-1:0]                 w_nxt_row, w_nxt_kr, w_nxt_col;
    int unsigned                      w_row, w_col;
    logic [DATA_WIDTH-1:0]            w_lane [WIDTH];
    logic [WIDTH*DATA_WIDTH-1:0]      w_od;

    // Start decode, next unskewed vector and skewed output word
    always_comb begin
        w_legal = (ifmap_height_i != '0) && (32'(ifmap_height_i) <= HEIGHT) &&
                  (ifmap_width_i != '0) && (32'(ifmap_width_i) <= WIDTH) &&
                  (op_i || ((weight_height_i != '0) &&
                            (weight_height_i <= ifmap_height_i) &&
                            (weight_height_i <= ifmap_width_i)));
        w_o_in      = ifmap_height_i - weight_height_i + DIM_W'(1);
        w_p_in      = ifmap_width_i - weight_height_i + DIM_W'(1);
        w_n_in      = op_i ? CNT_W'(ifmap_height_i)
                           : CNT_W'(weight_height_i) * CNT_W'(w_o_in) * CNT_W'(w_p_in);
        w_l_in      = op_i ? ifmap_width_i : weight_height_i;
        w_t_last_in = w_n_in + CNT_W'(w_l_in) - CNT_W'(2);

        w_finish = (r_state == S_SEND) && (r_t == r_t_last);
        w_start  = ((r_state == S_IDLE) || w_finish) && send_sd_en &&
                   layer_info_valid && w_legal;
        w_gen    = (r_n < r_n_max);

        // Walk order: output row, kernel row, output column (innermost)
        w_nxt_row = r_row;
        w_nxt_kr  = r_kr;
        w_nxt_col = r_col;
        if (r_op) begin
            w_nxt_row = r_row + DIM_W'(1);
        end else if (r_col == r_p - DIM_W'(1)) begin
            w_nxt_col = '0;
            if (r_kr == r_k - DIM_W'(1)) begin
                w_nxt_kr  = '0;
                w_nxt_row = r_row + DIM_W'(1);
            end else begin
                w_nxt_kr = r_kr + DIM_W'(1);
            end
        end else begin
            w_nxt_col = r_col + DIM_W'(1);
        end

        w_row = 0;
        w_col = 0;
        w_od  = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            w_lane[j] = '0;
            if (w_start) begin
                if (j < 32'(w_l_in))
                    w_lane[j] = ifmap_i[IDX_W'(j*DATA_WIDTH) +: DATA_WIDTH];
            end else if (w_gen && (j < 32'(r_l))) begin
                w_row = r_op ? 32'(w_nxt_row) : 32'(w_nxt_row) + 32'(w_nxt_kr);
                w_col = r_op ? j : 32'(w_nxt_col) + j;
                if ((w_row < HEIGHT) && (w_col < WIDTH))
                    w_lane[j] = r_ifmap[IDX_W'((w_row*WIDTH + w_col)*DATA_WIDTH) +: DATA_WIDTH];
            end
        end

        // Lane j shows the vector generated j cycles ago
        w_od[DATA_WIDTH-1:0] = w_lane[0];
        for (int unsigned j = 1; j < WIDTH; j++)
            w_od[j*DATA_WIDTH +: DATA_WIDTH] = w_start ? '0 : r_dly[j][j-1];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_ifmap  <= '0;
            r_op     <= 1'b0;
            r_k      <= '0;
            r_p      <= '0;
            r_l      <= '0;
            r_row    <= '0;
            r_kr     <= '0;
            r_col    <= '0;
            r_n      <= '0;
            r_n_max  <= '0;
            r_t      <= '0;
            r_t_last <= '0;
            sd_ov    <= 1'b0;
            sd_od    <= '0;
            for (int unsigned j = 0; j < WIDTH; j++)
                for (int unsigned k = 0; k < WIDTH; k++)
                    r_dly[j][k] <= '0;
        end else if (w_start) begin
            r_state  <= S_SEND;
            r_ifmap  <= ifmap_i;
            r_op     <= op_i;
            r_k      <= weight_height_i;
            r_p      <= w_p_in;
            r_l      <= w_l_in;
            r_row    <= '0;
            r_kr     <= '0;
            r_col    <= '0;
            r_n      <= CNT_W'(1);
            r_n_max  <= w_n_in;
            r_t      <= '0;
            r_t_last <= w_t_last_in;
            sd_ov    <= 1'b1;
            sd_od    <= w_od;
            for (int unsigned j = 0; j < WIDTH; j++)
                for (int unsigned k = 0; k < WIDTH; k++)
                    r_dly[j][k] <= (k == 0) ? w_lane[j] : '0;
        end else if (w_finish) begin
            r_state <= S_IDLE;
            sd_ov   <= 1'b0;
            sd_od   <= '0;
        end else if (r_state == S_SEND) begin
            r_t   <= r_t + CNT_W'(1);
            sd_ov <= 1'b1;
            sd_od <= w_od;
            if (w_gen) begin
                r_n   <= r_n + CNT_W'(1);
                r_row <= w_nxt_row;
                r_kr  <= w_nxt_kr;
                r_col <= w_nxt_col;
            end
            for (int unsigned j = 0; j < WIDTH; j++)
                for (int unsigned k = 0; k < WIDTH; k++)
                    r_dly[j][k] <= (k == 0) ? w_lane[j] : r_dly[j][k-1];
        end
    end

endmodule

// File: tb/tb_systolic_data_buffer.sv
// Scoreboard bench for systolic_data_buffer: stimulus queues expected skewed words,
// a negedge monitor pops and compares them whenever sd_ov is high.
module tb_systolic_data_buffer;

    localparam int DW = 8;
    localparam int HT = 8;
    localparam int WD = 8;
    localparam int HW = $clog2(HT);

    typedef logic [WD*DW-1:0] vec_t;

    logic                    clk = 1'b0;
    logic                    nrst;
    logic                    layer_info_valid;
    logic [HW:0]             ifmap_height_i, ifmap_width_i, weight_height_i;
    logic                    op_i;
    logic [HT*WD*DW-1:0]     ifmap_i;
    logic                    send_sd_en;
    logic                    sd_ov;
    vec_t                    sd_od;

    vec_t exp_q[$];
    vec_t cap [0:127];
    int   vcnt;
    bit   mon_en;
    int   n_pass;
    int   n_total;

    systolic_data_buffer #(.DATA_WIDTH(DW), .HEIGHT(HT), .WIDTH(WD)) dut (
        .clk(clk), .nrst(nrst), .layer_info_valid(layer_info_valid),
        .ifmap_height_i(ifmap_height_i), .ifmap_width_i(ifmap_width_i),
        .weight_height_i(weight_height_i), .op_i(op_i), .ifmap_i(ifmap_i),
        .send_sd_en(send_sd_en), .sd_ov(sd_ov), .sd_od(sd_od)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic int ifm(int r, int c, int h, int w, int pat);
        if (r < h && c < w) return (pat != 0) ? r*16 + c + 1 : r + c + 1;
        return 0;
    endfunction

    function automatic logic [HT*WD*DW-1:0] build_ifmap(int h, int w, int pat);
        logic [HT*WD*DW-1:0] m = '0;
        for (int r = 0; r < HT; r++)
            for (int c = 0; c < WD; c++)
                m[(r*WD + c)*DW +: DW] = DW'(ifm(r, c, h, w, pat));
        return m;
    endfunction

    // Element j of unskewed vector n, derived by index decomposition
    function automatic int vel(int op, int h, int w, int k, int pat, int n, int j);
        int p, r, rem, kr, c;
        if (op != 0) return ifm(n, j, h, w, pat);
        p   = w - k + 1;
        r   = n / (k*p);
        rem = n % (k*p);
        kr  = rem / p;
        c   = rem % p;
        return ifm(r + kr, c + j, h, w, pat);
    endfunction

    task automatic push_exp(input int op, input int h, input int w, input int k, input int pat,
                            output int cyc);
        int nn, ll;
        vec_t v;
        nn = (op != 0) ? h : k*(h-k+1)*(w-k+1);
        ll = (op != 0) ? w : k;
        for (int t = 0; t <= nn + ll - 2; t++) begin
            v = '0;
            for (int j = 0; j < ll; j++)
                if (t - j >= 0 && t - j < nn)
                    v[j*DW +: DW] = DW'(vel(op, h, w, k, pat, t - j, j));
            exp_q.push_back(v);
        end
        cyc = nn + ll - 1;
    endtask

    task automatic drive(input int op, input int h, input int w, input int k, input int pat);
        op_i            = op[0];
        ifmap_height_i  = (HW+1)'(h);
        ifmap_width_i   = (HW+1)'(w);
        weight_height_i = (HW+1)'(k);
        ifmap_i         = build_ifmap(h, w, pat);
    endtask

    task automatic wait_vcnt(input int target, input int budget);
        for (int i = 0; i < budget && vcnt < target; i++) @(posedge clk);
        if (vcnt < target) check("timeout", 72'(vcnt), 72'(target));
    endtask

    task automatic run(input int op, input int h, input int w, input int k, input int pat,
                       input int hand_cyc, input string name);
        int cyc;
        @(posedge clk); #1;
        drive(op, h, w, k, pat);
        send_sd_en = 1'b1;
        layer_info_valid = 1'b1;
        vcnt = 0;
        push_exp(op, h, w, k, pat, cyc);
        @(posedge clk); #1;
        send_sd_en = 1'b0;
        layer_info_valid = 1'b0;
        wait_vcnt(cyc, cyc + 20);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid_cycles"}, 72'(vcnt), 72'(hand_cyc));
        check({name, "_queue_empty"}, 72'(exp_q.size()), 72'(0));
    endtask

    function automatic int lane(vec_t v, int j);
        return int'(v[j*DW +: DW]);
    endfunction

    // Monitor: scoreboard pop on valid, zero data when idle
    always @(negedge clk) begin
        vec_t e;
        if (mon_en) begin
            if (sd_ov === 1'b1) begin
                if (vcnt < 128) cap[vcnt] = sd_od;
                vcnt++;
                if (exp_q.size() == 0) check("unexpected_valid", 72'(sd_od), 72'(0));
                else begin
                    e = exp_q.pop_front();
                    check("sd_od", 72'(sd_od), 72'(e));
                end
            end else begin
                check("idle_zero", {7'd0, sd_ov, sd_od}, 72'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seq_k1 [16] = '{1,2,3,4,2,3,4,5,3,4,5,6,4,5,6,7};
        int cyc;
        n_pass = 0; n_total = 0; vcnt = 0; mon_en = 0;
        nrst = 1'b0; send_sd_en = 1'b0; layer_info_valid = 1'b0;
        drive(1, 8, 8, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ov", 72'(sd_ov), 72'(0));
        check("reset_od", 72'(sd_od), 72'(0));
        @(negedge clk) nrst = 1'b1;
        @(posedge clk) mon_en = 1;

        // Request without layer_info_valid is ignored
        @(posedge clk); #1;
        drive(1, 8, 8, 0, 0);
        send_sd_en = 1'b1;
        @(posedge clk); #1;
        send_sd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("no_layer_valid_ov", 72'(sd_ov), 72'(0));

        // Illegal parameter sets are ignored
        @(posedge clk); #1;
        layer_info_valid = 1'b1; send_sd_en = 1'b1;
        drive(0, 3, 3, 4, 0);
        @(posedge clk); #1 drive(1, 0, 4, 0, 0);
        @(posedge clk); #1 drive(1, 4, 9, 0, 0);
        @(posedge clk); #1 drive(0, 4, 4, 0, 0);
        @(posedge clk); #1;
        send_sd_en = 1'b0; layer_info_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("illegal_ov", 72'(sd_ov), 72'(0));

        // MUL 8x8
        run(1, 8, 8, 0, 0, 15, "mul8x8");
        check("mul8_t0", 72'(cap[0]), 72'(1));
        check("mul8_t14", 72'(cap[14]), {8'd0, 8'd15, 56'd0});
        check("mul8_t5_l3", 72'(lane(cap[5], 3)), 72'(6));

        // CONV 6x6 K=3
        run(0, 6, 6, 3, 0, 50, "conv6k3");
        check("conv6_t0_l0", 72'(lane(cap[0], 0)), 72'(1));
        check("conv6_t2", 72'(cap[2]), 72'(24'h030303));
        for (int i = 0; i < 50; i++) check("conv6_hi_lanes", 72'(cap[i] >> 24), 72'(0));

        // MUL H=3 W=8
        run(1, 3, 8, 0, 0, 10, "mul3x8");
        for (int i = 0; i < 3; i++) check("mul3_l0", 72'(lane(cap[i], 0)), 72'(i + 1));
        check("mul3_t3_l0", 72'(lane(cap[3], 0)), 72'(0));
        check("mul3_t9", 72'(cap[9]), {8'd0, 8'd10, 56'd0});

        // CONV 4x4 K=1
        run(0, 4, 4, 1, 0, 16, "conv4k1");
        for (int i = 0; i < 16; i++) begin
            check("conv4k1_l0", 72'(lane(cap[i], 0)), 72'(seq_k1[i]));
            check("conv4k1_hi", 72'(cap[i] >> 8), 72'(0));
        end

        // Asymmetric CONV with row-distinct pattern
        run(0, 5, 7, 2, 1, 4*6*2 + 1, "conv5x7k2");
        check("conv5x7_t1", 72'(cap[1]), 72'(16'h0202));

        // Back-to-back: inputs change during SEND, next start taken as sd_ov falls
        @(posedge clk); #1;
        drive(1, 2, 2, 0, 1);
        send_sd_en = 1'b1; layer_info_valid = 1'b1;
        vcnt = 0;
        push_exp(1, 2, 2, 0, 1, cyc);
        @(posedge clk); #1;
        drive(1, 1, 3, 0, 0);
        push_exp(1, 1, 3, 0, 0, cyc);
        wait_vcnt(3, 20);
        @(posedge clk); #1;
        send_sd_en = 1'b0; layer_info_valid = 1'b0;
        wait_vcnt(6, 20);
        @(posedge clk);
        @(negedge clk);
        check("b2b_valid_cycles", 72'(vcnt), 72'(6));
        check("b2b_queue_empty", 72'(exp_q.size()), 72'(0));

        // Reset in the middle of a CONV transfer
        @(posedge clk); #1;
        drive(0, 6, 6, 3, 0);
        send_sd_en = 1'b1; layer_info_valid = 1'b1;
        vcnt = 0;
        push_exp(0, 6, 6, 3, 0, cyc);
        @(posedge clk); #1;
        send_sd_en = 1'b0; layer_info_valid = 1'b0;
        wait_vcnt(10, 30);
        #2;
        mon_en = 0;
        nrst = 1'b0;
        #1;
        check("midreset_ov", 72'(sd_ov), 72'(0));
        check("midreset_od", 72'(sd_od), 72'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk) mon_en = 1;
        repeat (5) @(posedge clk);
        #1 check("post_reset_idle", 72'(sd_ov), 72'(0));
        run(0, 6, 6, 3, 0, 50, "restart");
        check("restart_t0", 72'(cap[0]), 72'(1));
        check("restart_t1", 72'(cap[1]), 72'(16'h0202));

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/systolic_data_buffer.md
SYSTOLIC_DATA_BUFFER -- requirements
Module: systolic_data_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 Parameter HEIGHT, default 8, ifmap rows held.
REQ-003 Parameter WIDTH, default 8, ifmap columns held and number of output lanes.
REQ-004 Parameter HEIGHT_W, default $clog2(HEIGHT), dimension field width minus one.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 layer_info_valid  input  1  dimension/op inputs valid.
REQ-008 ifmap_height_i  input  HEIGHT_W+1  ifmap rows H.
REQ-009 ifmap_width_i  input  HEIGHT_W+1  ifmap columns W.
REQ-010 weight_height_i  input  HEIGHT_W+1  conv kernel size K (KxK).
REQ-011 op_i  input  1  0=CONV, 1=MUL.
REQ-012 ifmap_i  input  HEIGHT*WIDTH*DATA_WIDTH  element [r][c] at bits ((r*WIDTH+c)*DATA_WIDTH) upward.
REQ-013 send_sd_en  input  1  start request.
REQ-014 sd_ov  output  1  sd_od valid.
REQ-015 sd_od  output  WIDTH*DATA_WIDTH  lane j at bits (j*DATA_WIDTH) upward.

Function
REQ-016 States IDLE, SEND; SEND->IDLE on clock edge after last skewed element leaves.
REQ-017 Start: rising edge in IDLE with send_sd_en=1, layer_info_valid=1, legal parameters; edge captures H, W, K, op, full ifmap_i.
REQ-018 Legal: 1<=H<=HEIGHT, 1<=W<=WIDTH; CONV also 1<=K<=min(H,W); illegal requests ignored, stay IDLE.
REQ-019 send_sd_en ignored in SEND and when layer_info_valid=0; later input changes do not affect active transfer.
REQ-020 Unskewed vector stream v[n], n=0..N-1, active lanes L; elements on lanes >= L are 0.
REQ-021 MUL: N=H, L=W, v[n][j]=ifmap[n][j].
REQ-022 CONV (stride 1, no pad): O=H-K+1, P=W-K+1, N=K*O*P, L=K; order out row r (outer), kernel row kr, out col c (inner); v[n][j]=ifmap[r+kr][c+j].
REQ-023 Skew: cycle t (t=0 first cycle after start edge) lane j carries v[t-j][j] when 0<=t-j<N and j<L, else 0.
REQ-024 sd_ov=1 for exactly N+L-1 consecutive cycles t=0..N+L-2, then 0; sd_od=0 whenever sd_ov=0.
REQ-025 Outputs registered; latency start edge -> first valid output = 1 cycle.
REQ-026 New start accepted earliest on edge at which sd_ov falls.
REQ-027 Dimension fields unsigned; no arithmetic overflow within legal ranges.

Reset
REQ-028 nrst=0 immediately forces IDLE, sd_ov=0, sd_od=0, clears delay/capture registers, including mid-transfer.
REQ-029 After nrst rises, no output until a new legal start.

Verification (ifmap[r][c]=r+c+1 inside HxW, 0 elsewhere)
REQ-030 send_sd_en pulse with layer_info_valid=0 -> sd_ov stays 0, sd_od=0.
REQ-031 MUL H=W=8 -> sd_ov 15 cycles; every active lane at cycle t = t+1; t=0 only lane0=1; t=14 only lane7=15.
REQ-032 CONV H=W=6 K=3 -> N=48, sd_ov 50 cycles; t=0 lane0=1; t=2 lanes0-2=3; lanes3-7 always 0.
REQ-033 MUL H=3 W=8 -> sd_ov 10 cycles; lane0 valid t=0..2 (1,2,3); t=9 lane7=10.
REQ-034 CONV H=W=4 K=1 -> sd_ov 16 cycles; lane0 = 1,2,3,4,2,3,4,5,3,4,5,6,4,5,6,7; lanes1-7 0.
REQ-035 nrst low mid CONV transfer -> sd_ov, sd_od 0 at once; send_sd_en after release restarts from t=0.
